// File: rtl/seg7_frame_decoder_if.sv
// seg7_frame_decoder_if: display bus (seg/an) plus frame valid/ready handshake
//   seg         7-bit active-low segments, seg[0]=A .. seg[6]=G
//   an          NUM_DIGITS active-low digit selects
//   frame_ready consumer accepts the presented frame
//   frame_valid frame held on frame_bcd/frame_blank/frame_err
//   master = display + frame consumer side, slave = decoder side
interface seg7_frame_decoder_if #(parameter int NUM_DIGITS = 4);
  logic [6:0] seg;
  logic [NUM_DIGITS-1:0] an;
  logic frame_ready;
  logic frame_valid;
  logic [4*NUM_DIGITS-1:0] frame_bcd;
  logic [NUM_DIGITS-1:0] frame_blank;
  logic [NUM_DIGITS-1:0] frame_err;
  modport master(output seg, an, frame_ready, input frame_valid, frame_bcd, frame_blank, frame_err);
  modport slave(input seg, an, frame_ready, output frame_valid, frame_bcd, frame_blank, frame_err);
endinterface

// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder: scrapes a multiplexed 7-segment bus back into BCD frames
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave side of seg7_frame_decoder_if (seg/an in, frame handshake out)
module seg7_frame_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input logic clk,
  input logic rst,
  seg7_frame_decoder_if.slave bus
);
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;
  localparam logic [3:0] SC = 4'(STABLE_CYCLES);
  logic [6:0] s_seg_q, p_seg_q;
  logic [NUM_DIGITS-1:0] s_an_q, p_an_q, sel, mask_q, mask_d;
  logic [3:0] cnt_q, cnt_d, dec_bcd;
  logic chg, an_ok, stb, dec_blank, dec_err;
  logic [0:0] state_q;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [NUM_DIGITS-1:0] blank_q, err_q;
  // p_* holds the previous registered sample so a change is seen one cycle after capture
  always_comb begin
    chg = {s_an_q, s_seg_q} != {p_an_q, p_seg_q};
    cnt_d = chg ? 4'd1 : (cnt_q == SC ? SC : cnt_q + 4'd1);
    sel = ~s_an_q;
    an_ok = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
    // the saturated case keeps cnt_d == SC, so require an actual arrival
    stb = (cnt_d == SC) && (chg || cnt_q != SC) && an_ok;
    mask_d = mask_q | sel;
  end
  always_comb begin
    dec_bcd = 4'hE;
    dec_blank = 1'b0;
    dec_err = 1'b1;
    case (s_seg_q)
      7'h40: dec_bcd = 4'd0;
      7'h79: dec_bcd = 4'd1;
      7'h24: dec_bcd = 4'd2;
      7'h30: dec_bcd = 4'd3;
      7'h19: dec_bcd = 4'd4;
      7'h12: dec_bcd = 4'd5;
      7'h02: dec_bcd = 4'd6;
      7'h78: dec_bcd = 4'd7;
      7'h00: dec_bcd = 4'd8;
      7'h10: dec_bcd = 4'd9;
      7'h7F: dec_bcd = 4'hF;
      default: dec_bcd = 4'hE;
    endcase
    dec_blank = s_seg_q == 7'h7F;
    dec_err = dec_bcd == 4'hE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg_q <= '1;
      p_seg_q <= '1;
      s_an_q <= '1;
      p_an_q <= '1;
      cnt_q <= '0;
      mask_q <= '0;
      state_q <= COLLECT;
      bcd_q <= '0;
      blank_q <= '0;
      err_q <= '0;
    end else begin
      s_seg_q <= bus.seg;
      s_an_q <= bus.an;
      p_seg_q <= s_seg_q;
      p_an_q <= s_an_q;
      cnt_q <= cnt_d;
      if (state_q == PRESENT) begin
        if (bus.frame_ready) begin
          state_q <= COLLECT;
          mask_q <= '0;
        end
      end else if (stb) begin
        mask_q <= mask_d;
        if (&mask_d) state_q <= PRESENT;
        for (int i = 0; i < NUM_DIGITS; i++)
          if (sel[i]) begin
            bcd_q[4*i+:4] <= dec_bcd;
            blank_q[i] <= dec_blank;
            err_q[i] <= dec_err;
          end
      end
    end
  end
  assign bus.frame_valid = state_q == PRESENT;
  assign bus.frame_bcd = bcd_q;
  assign bus.frame_blank = blank_q;
  assign bus.frame_err = err_q;
endmodule

// File: tb/tb_seg7_frame_decoder.sv
// tb_seg7_frame_decoder: directed self-checking bench for seg7_frame_decoder
module tb_seg7_frame_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  seg7_frame_decoder_if #(.NUM_DIGITS(4)) bus();
  seg7_frame_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
    bus.an = an;
    bus.seg = seg;
    step(n);
  endtask
  task automatic scan4(input logic [6:0] s0, s1, s2, s3, input int n);
    show(4'b1110, s0, n);
    show(4'b1101, s1, n);
    show(4'b1011, s2, n);
    show(4'b0111, s3, n);
  endtask
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && bus.frame_valid !== 1'b1; i++) step(1);
    chk(tag, 16'(bus.frame_valid), 16'd1);
  endtask
  task automatic handshake(input string tag);
    bus.frame_ready = 1'b1;
    step(1);
    bus.frame_ready = 1'b0;
    chk(tag, 16'(bus.frame_valid), 16'd0);
  endtask
  initial begin
    bus.an = 4'b0110;
    bus.seg = 7'h24;
    bus.frame_ready = 1'b1;
    step(2);
    chk("rst_valid", 16'(bus.frame_valid), 16'd0);
    chk("rst_bcd", bus.frame_bcd, 16'h0000);
    chk("rst_blank", 16'(bus.frame_blank), 16'd0);
    chk("rst_err", 16'(bus.frame_err), 16'd0);
    rst = 1'b0;
    bus.frame_ready = 1'b0;
    show(4'b1110, 7'h24, 4);
    show(4'b1101, 7'h30, 4);
    show(4'b1011, 7'h19, 4);
    chk("basic_partial_valid", 16'(bus.frame_valid), 16'd0);
    show(4'b0111, 7'h40, 4);
    wait_valid("basic_valid");
    chk("basic_bcd", bus.frame_bcd, 16'h0432);
    chk("basic_blank", 16'(bus.frame_blank), 16'd0);
    chk("basic_err", 16'(bus.frame_err), 16'd0);
    step(1);
    chk("basic_hold_valid", 16'(bus.frame_valid), 16'd1);
    handshake("basic_release");
    step(3);
    chk("basic_idle_valid", 16'(bus.frame_valid), 16'd0);
    show(4'b1110, 7'h79, 2);
    show(4'b1110, 7'h12, 3);
    show(4'b1101, 7'h02, 4);
    show(4'b1011, 7'h78, 4);
    chk("glitch_partial_valid", 16'(bus.frame_valid), 16'd0);
    show(4'b0111, 7'h79, 2);
    chk("glitch_short_valid", 16'(bus.frame_valid), 16'd0);
    show(4'b0111, 7'h10, 4);
    wait_valid("glitch_valid");
    chk("glitch_bcd", bus.frame_bcd, 16'h9765);
    handshake("glitch_release");
    scan4(7'h40, 7'h79, 7'h7F, 7'h55, 4);
    wait_valid("blank_valid");
    chk("blank_bcd", bus.frame_bcd, 16'hEF10);
    chk("blank_blank", 16'(bus.frame_blank), 16'b0100);
    chk("blank_err", 16'(bus.frame_err), 16'b1000);
    scan4(7'h30, 7'h24, 7'h79, 7'h40, 5);
    chk("bp_valid", 16'(bus.frame_valid), 16'd1);
    chk("bp_bcd", bus.frame_bcd, 16'hEF10);
    chk("bp_blank", 16'(bus.frame_blank), 16'b0100);
    chk("bp_err", 16'(bus.frame_err), 16'b1000);
    handshake("bp_release");
    show(4'b1110, 7'h19, 4);
    show(4'b1101, 7'h12, 4);
    show(4'b1011, 7'h02, 4);
    chk("bp_partial_valid", 16'(bus.frame_valid), 16'd0);
    show(4'b0111, 7'h00, 4);
    wait_valid("bp_next_valid");
    chk("bp_next_bcd", bus.frame_bcd, 16'h8654);
    chk("bp_next_blank", 16'(bus.frame_blank), 16'd0);
    chk("bp_next_err", 16'(bus.frame_err), 16'd0);
    handshake("bp_next_release");
    show(4'b1110, 7'h24, 4);
    show(4'b1101, 7'h30, 4);
    show(4'b1011, 7'h19, 4);
    show(4'b0011, 7'h12, 5);
    show(4'b1111, 7'h02, 5);
    show(4'b0000, 7'h00, 5);
    chk("illegal_an_valid", 16'(bus.frame_valid), 16'd0);
    chk("illegal_an_bcd", bus.frame_bcd, 16'h8432);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_valid", 16'(bus.frame_valid), 16'd0);
    chk("midrst_bcd", bus.frame_bcd, 16'h0000);
    show(4'b0111, 7'h78, 6);
    chk("midrst_partial_valid", 16'(bus.frame_valid), 16'd0);
    show(4'b1110, 7'h40, 4);
    show(4'b1101, 7'h79, 4);
    chk("midrst_partial2_valid", 16'(bus.frame_valid), 16'd0);
    show(4'b1011, 7'h00, 4);
    wait_valid("midrst_frame_valid");
    chk("midrst_frame_bcd", bus.frame_bcd, 16'h7810);
    handshake("midrst_release");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
